pcpi_mul_arbiter: RTL and testbench
===================================

PCPI_MUL_ARBITER -- requirements
Module: pcpi_mul_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, range 1..255: maximum cycles in ISSUE without m_ready before a forced completion.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 resetn  input  1  reset, synchronous, active-low.
REQ-004 rN_valid, N=0,1  input  1  requester N has a PCPI instruction pending.
REQ-005 rN_insn  input  32  requester N instruction word.
REQ-006 rN_rs1, rN_rs2  input  32  requester N operands.
REQ-007 rN_wr  output  1  requester N result write enable, valid with rN_ready.
REQ-008 rN_rd  output  32  requester N result, valid with rN_ready.
REQ-009 rN_wait  output  1  requester N request accepted or queued, completion pending.
REQ-010 rN_ready  output  1  requester N one-cycle completion strobe.
REQ-011 m_valid  output  1  request to the shared multiplier.
REQ-012 m_insn, m_rs1, m_rs2  output  32 each  latched instruction and operands to the multiplier.
REQ-013 m_wr, m_ready  input  1 each  multiplier completion signals.
REQ-014 m_rd  input  32  multiplier result.
REQ-015 busy  output  1  high whenever state is not IDLE.
REQ-016 timeout_err  output  1  one-cycle pulse on forced completion.

Function
REQ-017 Eligible request: rN_valid=1, insn[6:0]=0110011, insn[31:25]=0000001, insn[14:12] in 000..011, and holdN=0; all other requests are ignored with rN_wait=0 and rN_ready=0.
REQ-018 FSM states: IDLE, ISSUE, DONE; reset state IDLE.
REQ-019 IDLE: if any request is eligible, grant one, latch its insn/rs1/rs2 and the grant index, then go to ISSUE; otherwise stay in IDLE.
REQ-020 Round-robin: if both requests are eligible, grant the requester not granted last; pointer last=1 after reset, so r0 wins the first tie.
REQ-021 ISSUE: m_valid=1 with the latched fields; on m_ready=1, capture m_rd and m_wr and go to DONE.
REQ-022 m_valid SHALL be combinationally (state==ISSUE) and SHALL be 0 in the cycle after m_ready, so the multiplier is never re-triggered.
REQ-023 DONE lasts exactly one cycle, then returns to IDLE; in DONE, granted rN_ready=1 and rN_wr/rN_rd carry the captured values.
REQ-024 Outside DONE, rN_ready=0, rN_wr=0 and rN_rd=0.
REQ-025 rN_ready is suppressed in DONE if the granted rN_valid is 0 (aborted request); the result is discarded and the FSM still returns to IDLE.
REQ-026 holdN is set in DONE for the granted requester and cleared in any cycle rN_valid=0; this prevents reissue of a still-asserted valid.
REQ-027 rN_wait = eligible AND NOT rN_ready.
REQ-028 Latency: eligible request in IDLE at cycle t with multiplier latency L (m_ready at ISSUE cycle t+L) gives rN_ready at cycle t+L+1.
REQ-029 An 8-bit timeout counter clears on entry to ISSUE and increments each ISSUE cycle.
REQ-030 If the counter reaches TIMEOUT_CYCLES with m_ready=0, go to DONE with captured rd=0 and wr=0, and pulse timeout_err in that DONE cycle.
REQ-031 If m_ready=1 in the same cycle the counter reaches TIMEOUT_CYCLES, it is a normal completion with no timeout_err.
REQ-032 Requests arriving while not in IDLE are queued by their held valid; there is no internal FIFO.
REQ-033 The arbitration pointer updates only on grant.

Reset
REQ-034 On resetn=0 at a clock edge, including mid-ISSUE or mid-DONE, the block SHALL force: state=IDLE, last=1, hold0=hold1=0, timeout counter=0, latched fields=0, and all outputs 0.
REQ-035 A completion pending at reset is lost: no rN_ready is produced for it, and m_ready arriving after reset is ignored in IDLE.

Verification
REQ-036 Single request: r0 MUL, rs1=7, rs2=6, multiplier L=1 -> m_valid one cycle, r0_ready at t+2, r0_wr=1, r0_rd=42, r1 outputs 0.
REQ-037 Tie: r0 and r1 both MULHU, rs1=rs2=0xFFFFFFFF -> r0 served first with rd=0xFFFFFFFE, then r1 with rd=0xFFFFFFFE, no overlap of m_valid periods.
REQ-038 Hold: r0 keeps valid high 3 cycles after r0_ready -> no second grant to r0 until valid drops; r1 request during that window is granted at once.
REQ-039 Timeout: TIMEOUT_CYCLES=4, m_ready tied 0 -> r0_ready=1, r0_wr=0, r0_rd=0, timeout_err one pulse, busy low afterwards.
REQ-040 Non-MUL filter: r1 insn funct7=0000000 (ADD) or funct3=100 (DIV) -> r1_wait=0, no m_valid, busy=0.
REQ-041 Reset in ISSUE: resetn=0 one cycle while m_valid=1 -> all outputs 0 next cycle, no r0_ready, next r0 request served normally.

Source files
------------

// File: rtl/pcpi_mul_arbiter.sv
// Two-requester arbiter in front of one shared PCPI multiplier.
// A request is granted in IDLE (round-robin on a tie), held in ISSUE until the
// multiplier answers or the timeout expires, and completed with a one-cycle
// DONE strobe back to the granted requester.
module pcpi_mul_arbiter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        r0_valid,
  input  logic [31:0] r0_insn,
  input  logic [31:0] r0_rs1,
  input  logic [31:0] r0_rs2,
  output logic        r0_wr,
  output logic [31:0] r0_rd,
  output logic        r0_wait,
  output logic        r0_ready,
  input  logic        r1_valid,
  input  logic [31:0] r1_insn,
  input  logic [31:0] r1_rs1,
  input  logic [31:0] r1_rs2,
  output logic        r1_wr,
  output logic [31:0] r1_rd,
  output logic        r1_wait,
  output logic        r1_ready,
  output logic        m_valid,
  output logic [31:0] m_insn,
  output logic [31:0] m_rs1,
  output logic [31:0] m_rs2,
  input  logic        m_wr,
  input  logic        m_ready,
  input  logic [31:0] m_rd,
  output logic        busy,
  output logic        timeout_err
);

  localparam logic [7:0] TMO = 8'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t      state, state_nxt;
  logic        grant_q, grant_nxt;
  logic        last_q;
  logic        hold0, hold1;
  logic [7:0]  tcnt;
  logic [31:0] insn_q, rs1_q, rs2_q, rd_q;
  logic        wr_q, to_q;
  logic        elig0, elig1;
  logic        take, cap, tmo;
  logic        done;

  // MUL/MULH/MULHSU/MULHU: OP opcode, funct7 = MULDIV, funct3 below 100.
  function automatic logic is_mul(input logic [31:0] insn);
    return (insn[6:0] == 7'b0110011) && (insn[31:25] == 7'b0000001) && !insn[14];
  endfunction

  assign elig0 = r0_valid && is_mul(r0_insn) && !hold0;
  assign elig1 = r1_valid && is_mul(r1_insn) && !hold1;

  // Next-state: grant in IDLE, wait for multiplier or timeout in ISSUE, one DONE cycle.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant_q;
    take      = 1'b0;
    cap       = 1'b0;
    tmo       = 1'b0;
    case (state)
      IDLE: begin
        if (elig0 || elig1) begin
          take      = 1'b1;
          grant_nxt = (elig0 && elig1) ? ~last_q : elig1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (m_ready) begin
          cap       = 1'b1;
          state_nxt = DONE;
        end else if ((tcnt + 8'd1) == TMO) begin
          tmo       = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, grant pointer, latched request, timeout counter and captured result.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      tcnt    <= 8'd0;
      insn_q  <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      wr_q    <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (take) begin
        grant_q <= grant_nxt;
        last_q  <= grant_nxt;
        insn_q  <= grant_nxt ? r1_insn : r0_insn;
        rs1_q   <= grant_nxt ? r1_rs1  : r0_rs1;
        rs2_q   <= grant_nxt ? r1_rs2  : r0_rs2;
        tcnt    <= 8'd0;
      end else if (state == ISSUE) begin
        tcnt <= tcnt + 8'd1;
      end
      if (cap) begin
        rd_q <= m_rd;
        wr_q <= m_wr;
        to_q <= 1'b0;
      end else if (tmo) begin
        rd_q <= '0;
        wr_q <= 1'b0;
        to_q <= 1'b1;
      end
    end
  end

  // Hold flags block a still-asserted valid from being granted again after completion.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      hold0 <= 1'b0;
      hold1 <= 1'b0;
    end else begin
      if (!r0_valid)                      hold0 <= 1'b0;
      else if (state == DONE && !grant_q) hold0 <= 1'b1;
      if (!r1_valid)                      hold1 <= 1'b0;
      else if (state == DONE && grant_q)  hold1 <= 1'b1;
    end
  end

  // Outputs: completion only in DONE and only if the granted requester still asks.
  always_comb begin
    done        = (state == DONE);
    r0_ready    = done && !grant_q && r0_valid;
    r1_ready    = done && grant_q && r1_valid;
    r0_wr       = r0_ready && wr_q;
    r1_wr       = r1_ready && wr_q;
    r0_rd       = r0_ready ? rd_q : '0;
    r1_rd       = r1_ready ? rd_q : '0;
    r0_wait     = elig0 && !r0_ready;
    r1_wait     = elig1 && !r1_ready;
    m_valid     = (state == ISSUE);
    m_insn      = insn_q;
    m_rs1       = rs1_q;
    m_rs2       = rs2_q;
    busy        = (state != IDLE);
    timeout_err = done && to_q;
  end

endmodule

// File: tb/tb_pcpi_mul_arbiter.sv
// Bench for pcpi_mul_arbiter: vector table, hand-written corner sequences and a
// randomized run against a transaction-level reference model.
module tb_pcpi_mul_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        r0_valid, r1_valid;
  logic [31:0] r0_insn, r0_rs1, r0_rs2, r1_insn, r1_rs1, r1_rs2;
  logic        r0_wr, r0_wait, r0_ready, r1_wr, r1_wait, r1_ready;
  logic [31:0] r0_rd, r1_rd;
  logic        m_valid, m_wr, m_ready;
  logic [31:0] m_insn, m_rs1, m_rs2, m_rd;
  logic        busy, timeout_err;

  int total = 0;
  int bad   = 0;

  pcpi_mul_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .resetn(resetn),
    .r0_valid(r0_valid), .r0_insn(r0_insn), .r0_rs1(r0_rs1), .r0_rs2(r0_rs2),
    .r0_wr(r0_wr), .r0_rd(r0_rd), .r0_wait(r0_wait), .r0_ready(r0_ready),
    .r1_valid(r1_valid), .r1_insn(r1_insn), .r1_rs1(r1_rs1), .r1_rs2(r1_rs2),
    .r1_wr(r1_wr), .r1_rd(r1_rd), .r1_wait(r1_wait), .r1_ready(r1_ready),
    .m_valid(m_valid), .m_insn(m_insn), .m_rs1(m_rs1), .m_rs2(m_rs2),
    .m_wr(m_wr), .m_ready(m_ready), .m_rd(m_rd),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // RISC-V M-extension multiply results from 64-bit arithmetic.
  function automatic logic [31:0] mulres(input logic [31:0] insn, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (insn[13:12])
      2'd1:    p = 64'(sa * sb);
      2'd2:    p = 64'(sa * longint'({32'b0, b}));
      default: p = {32'b0, a} * {32'b0, b};
    endcase
    return (insn[13:12] == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  function automatic bit mul_op(input logic [31:0] w);
    return (w[6:0] == 7'h33) && (w[31:25] == 7'h01) && (int'(w[14:12]) < 4);
  endfunction

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3);
    return {f7, 5'd2, 5'd1, f3, 5'd3, 7'h33};
  endfunction

  // Multiplier stub: answers after lat ISSUE cycles with the true product.
  int         lat = 1;
  bit         mwr = 1'b1;
  bit         force_mr = 1'b0;
  logic [7:0] mcnt = 8'd0;
  always @(posedge clk) mcnt <= (m_valid === 1'b1 && m_ready !== 1'b1) ? mcnt + 8'd1 : 8'd0;
  assign m_ready = force_mr || (m_valid === 1'b1 && (int'(mcnt) + 1 == lat));
  assign m_wr    = mwr;
  assign m_rd    = mulres(m_insn, m_rs1, m_rs2);

  wire [168:0] all_o = {r0_wr, r0_rd, r0_wait, r0_ready, r1_wr, r1_rd, r1_wait, r1_ready,
                        m_valid, m_insn, m_rs1, m_rs2, busy, timeout_err};

  // Reference model: a transaction occupies min(lat,TO) issue cycles plus one done cycle.
  int          left = 0, cur = 0, rr = 1, next_lat = 1;
  bit          next_mwr = 1'b1, tox, l_wr, chk_en;
  bit          held[2];
  logic [31:0] l_insn, l_rs1, l_rs2, l_res;
  bit          e_wait[2], e_ready[2], e_wr[2];
  logic [31:0] e_rd[2];
  bit          e_mv, e_busy, e_to;

  task automatic chk1(input string nm, input logic [191:0] got, input logic [191:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0h want=%0h", nm, $time, got, exp);
    end
  endtask

  task automatic model_eval();
    bit          rv[2], el[2];
    logic [31:0] ri[2], ra[2], rb[2];
    int          g;
    rv = '{r0_valid, r1_valid};
    ri = '{r0_insn, r1_insn};
    ra = '{r0_rs1, r1_rs1};
    rb = '{r0_rs2, r1_rs2};
    e_wait = '{0, 0}; e_ready = '{0, 0}; e_wr = '{0, 0}; e_rd = '{32'd0, 32'd0};
    e_mv = 0; e_busy = 0; e_to = 0;
    chk_en = resetn;
    if (!resetn) begin
      left = 0; rr = 1; held = '{0, 0};
      return;
    end
    for (int n = 0; n < 2; n++) el[n] = rv[n] && mul_op(ri[n]) && !held[n];
    e_busy = (left > 0);
    if (left == 0) begin
      if (el[0] || el[1]) begin
        g      = (el[0] && el[1]) ? 1 - rr : (el[0] ? 0 : 1);
        cur    = g;
        rr     = g;
        tox    = (next_lat > TO);
        left   = (tox ? TO : next_lat) + 1;
        l_insn = ri[g]; l_rs1 = ra[g]; l_rs2 = rb[g];
        l_res  = tox ? 32'd0 : mulres(ri[g], ra[g], rb[g]);
        l_wr   = tox ? 1'b0 : next_mwr;
        lat    = next_lat;
        mwr    = next_mwr;
      end
    end else begin
      if (left > 1) begin
        e_mv = 1;
      end else begin
        e_ready[cur] = rv[cur];
        e_rd[cur]    = rv[cur] ? l_res : 32'd0;
        e_wr[cur]    = rv[cur] && l_wr;
        e_to         = tox;
        if (rv[cur]) held[cur] = 1;
      end
      left--;
    end
    for (int n = 0; n < 2; n++) begin
      e_wait[n] = el[n] && !e_ready[n];
      if (!rv[n]) held[n] = 0;
    end
  endtask

  task automatic compare();
    if (!chk_en) return;
    chk1("r0_out", 192'({r0_wait, r0_ready, r0_wr, r0_rd}), 192'({e_wait[0], e_ready[0], e_wr[0], e_rd[0]}));
    chk1("r1_out", 192'({r1_wait, r1_ready, r1_wr, r1_rd}), 192'({e_wait[1], e_ready[1], e_wr[1], e_rd[1]}));
    chk1("m_out", 192'({m_valid, (m_valid === 1'b1) ? {m_insn, m_rs1, m_rs2} : 96'd0}),
         192'({e_mv, e_mv ? {l_insn, l_rs1, l_rs2} : 96'd0}));
    chk1("status", 192'({busy, timeout_err}), 192'({e_busy, e_to}));
  endtask

  task automatic step_a();
    model_eval();
    @(negedge clk);
    compare();
  endtask

  task automatic step_b();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    step_a();
    step_b();
  endtask

  task automatic do_reset();
    resetn = 0; r0_valid = 0; r1_valid = 0; force_mr = 0;
    step();
    step();
    chk1("reset_state", 192'(all_o), 192'd0);
    resetn = 1;
  endtask

  task automatic serve(input int n, input int budget, output bit seen, output logic [31:0] rd);
    seen = 0;
    rd   = 32'd0;
    for (int c = 0; c < budget && !seen; c++) begin
      step_a();
      if ((n == 0) ? r0_ready : r1_ready) begin
        seen = 1;
        rd   = (n == 0) ? r0_rd : r1_rd;
      end
      step_b();
    end
  endtask

  typedef struct {
    logic [31:0] i0, a0, b0; bit v0;
    logic [31:0] i1, a1, b1; bit v1;
    int lat;
    bit s0, s1; logic [31:0] rd0, rd1; bit wr0, wr1;
    int first; int ntmo;
  } vec_t;

  vec_t tbl[8];

  // Random requester state.
  bit          rq_v[2], pend[2], lr[2];
  logic [31:0] rq_i[2], rq_a[2], rq_b[2];
  int          hl[2], il[2];

  function automatic logic [31:0] pick_op();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic new_req(input int n);
    int k;
    logic [6:0] f7;
    logic [2:0] f3;
    k  = $urandom_range(0, 99);
    f7 = 7'h01;
    f3 = 3'($urandom_range(0, 3));
    if (k < 12)      f7 = ($urandom_range(0, 1) == 0) ? 7'h00 : 7'h20;
    else if (k < 18) f3 = 3'($urandom_range(4, 7));
    rq_i[n] = {f7, 5'($urandom), 5'($urandom), f3, 5'($urandom), 7'h33};
    rq_a[n] = pick_op();
    rq_b[n] = pick_op();
    rq_v[n] = 1;
    pend[n] = (k >= 18);
    hl[n]   = pend[n] ? 0 : $urandom_range(1, 3);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "simulation did not finish");
  end

  initial begin
    bit          seen;
    logic [31:0] rd;
    int          got0, got1, first, ntmo;
    bit          mv_seen;

    resetn = 0; r0_valid = 0; r1_valid = 0;
    r0_insn = 0; r0_rs1 = 0; r0_rs2 = 0; r1_insn = 0; r1_rs1 = 0; r1_rs2 = 0;

    tbl[0] = '{mk(7'd1, 3'd0), 32'd7, 32'd6, 1'b1, 32'd0, 32'd0, 32'd0, 1'b0, 1,
               1'b1, 1'b0, 32'd42, 32'd0, 1'b1, 1'b0, 0, 0};
    tbl[1] = '{mk(7'd1, 3'd3), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1,
               mk(7'd1, 3'd3), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 2,
               1'b1, 1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 1'b1, 1'b1, 0, 0};
    tbl[2] = '{mk(7'd1, 3'd1), 32'hFFFF_FFFD, 32'd5, 1'b1, 32'd0, 32'd0, 32'd0, 1'b0, 2,
               1'b1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0, 0, 0};
    tbl[3] = '{32'd0, 32'd0, 32'd0, 1'b0, mk(7'd1, 3'd2), 32'h8000_0000, 32'h8000_0000, 1'b1, 3,
               1'b0, 1'b1, 32'd0, 32'hC000_0000, 1'b0, 1'b1, 1, 0};
    tbl[4] = '{32'd0, 32'd0, 32'd0, 1'b0, mk(7'd0, 3'd0), 32'd3, 32'd4, 1'b1, 1,
               1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, -1, 0};
    tbl[5] = '{32'd0, 32'd0, 32'd0, 1'b0, mk(7'd1, 3'd4), 32'd3, 32'd4, 1'b1, 1,
               1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, -1, 0};
    tbl[6] = '{mk(7'd1, 3'd0), 32'h0001_0001, 32'h0001_0000, 1'b1,
               mk(7'd1, 3'd0), 32'd3, 32'd5, 1'b1, TO,
               1'b1, 1'b1, 32'h0001_0000, 32'd15, 1'b1, 1'b1, 0, 0};
    tbl[7] = '{mk(7'd1, 3'd0), 32'd7, 32'd6, 1'b1, 32'd0, 32'd0, 32'd0, 1'b0, 10,
               1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 0, 1};

    @(posedge clk);
    #1;

    // Vector table.
    for (int i = 0; i < 8; i++) begin
      do_reset();
      r0_insn = tbl[i].i0; r0_rs1 = tbl[i].a0; r0_rs2 = tbl[i].b0; r0_valid = tbl[i].v0;
      r1_insn = tbl[i].i1; r1_rs1 = tbl[i].a1; r1_rs2 = tbl[i].b1; r1_valid = tbl[i].v1;
      next_lat = tbl[i].lat; next_mwr = 1;
      got0 = 0; got1 = 0; first = -1; ntmo = 0; mv_seen = 0;
      for (int c = 0; c < 24; c++) begin
        step_a();
        if (m_valid) mv_seen = 1;
        if (timeout_err) ntmo++;
        if (r0_ready) begin
          got0++;
          if (first < 0) first = 0;
          chk1("tbl_r0_res", 192'({r0_wr, r0_rd}), 192'({tbl[i].wr0, tbl[i].rd0}));
        end
        if (r1_ready) begin
          got1++;
          if (first < 0) first = 1;
          chk1("tbl_r1_res", 192'({r1_wr, r1_rd}), 192'({tbl[i].wr1, tbl[i].rd1}));
        end
        step_b();
        if (got0 > 0) r0_valid = 0;
        if (got1 > 0) r1_valid = 0;
      end
      chk1("tbl_served", 192'({got0, got1}), 192'({int'(tbl[i].s0), int'(tbl[i].s1)}));
      chk1("tbl_first", 192'(first), 192'(tbl[i].first));
      chk1("tbl_mvalid", 192'(mv_seen), 192'(tbl[i].s0 | tbl[i].s1));
      chk1("tbl_timeouts", 192'(ntmo), 192'(tbl[i].ntmo));
      chk1("tbl_idle", 192'(busy), 192'd0);
    end

    // Hold: r0 keeps valid 3 cycles after completion; r1 gets the multiplier at once.
    do_reset();
    r0_insn = mk(7'd1, 3'd0); r0_rs1 = 32'd9; r0_rs2 = 32'd9; r0_valid = 1;
    next_lat = 1; next_mwr = 1;
    serve(0, 10, seen, rd);
    chk1("hold_first", 192'({seen, rd}), 192'({1'b1, 32'd81}));
    r1_insn = mk(7'd1, 3'd0); r1_rs1 = 32'd4; r1_rs2 = 32'd5; r1_valid = 1;
    step_a();
    chk1("hold_no_rready", 192'(r0_ready), 192'd0);
    step_b();
    step_a();
    chk1("hold_grant_r1", 192'({m_valid, m_rs1, r0_ready}), 192'({1'b1, 32'd4, 1'b0}));
    step_b();
    step_a();
    chk1("hold_r1_done", 192'({r1_ready, r1_rd, r0_ready}), 192'({1'b1, 32'd20, 1'b0}));
    step_b();
    r0_valid = 0; r1_valid = 0;
    step();
    r0_rs1 = 32'd2; r0_rs2 = 32'd3; r0_valid = 1;
    serve(0, 10, seen, rd);
    chk1("hold_reissue", 192'({seen, rd}), 192'({1'b1, 32'd6}));
    r0_valid = 0;
    step();

    // Reset while the multiplier request is outstanding.
    do_reset();
    r0_insn = mk(7'd1, 3'd0); r0_rs1 = 32'd11; r0_rs2 = 32'd3; r0_valid = 1;
    next_lat = 5;
    step();
    step_a();
    chk1("rst_mvalid", 192'(m_valid), 192'd1);
    step_b();
    resetn = 0; r0_valid = 0;
    step();
    resetn = 1; force_mr = 1;
    step_a();
    chk1("rst_out0", 192'(all_o), 192'd0);
    step_b();
    force_mr = 0;
    step_a();
    chk1("rst_out1", 192'(all_o), 192'd0);
    step_b();
    r0_valid = 1; next_lat = 2;
    serve(0, 10, seen, rd);
    chk1("rst_after", 192'({seen, rd}), 192'({1'b1, 32'd33}));
    r0_valid = 0;
    step();

    // Randomized traffic against the model.
    do_reset();
    rq_v = '{0, 0}; pend = '{0, 0}; lr = '{0, 0}; hl = '{0, 0}; il = '{0, 2};
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int n = 0; n < 2; n++) begin
        if (rq_v[n]) begin
          if (pend[n]) begin
            if (lr[n]) begin
              pend[n] = 0;
              hl[n]   = $urandom_range(0, 2);
            end else if ($urandom_range(0, 99) < 2) begin
              rq_v[n] = 0; pend[n] = 0; il[n] = $urandom_range(0, 3);
            end
          end
          if (rq_v[n] && !pend[n]) begin
            if (hl[n] == 0) begin
              rq_v[n] = 0; il[n] = $urandom_range(0, 3);
            end else begin
              hl[n]--;
            end
          end
        end else if (il[n] == 0) begin
          new_req(n);
        end else begin
          il[n]--;
        end
      end
      r0_valid = rq_v[0]; r0_insn = rq_i[0]; r0_rs1 = rq_a[0]; r0_rs2 = rq_b[0];
      r1_valid = rq_v[1]; r1_insn = rq_i[1]; r1_rs1 = rq_a[1]; r1_rs2 = rq_b[1];
      next_lat = $urandom_range(1, 6);
      next_mwr = 1'($urandom_range(0, 1));
      step();
      lr = e_ready;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
